mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACCESS_CYCLES, default 4, total cycles one load/store occupies the stage (legal range 2..15).
REQ-002 Parameter MEM_BASE, default 1024, byte address of data-memory word 0.
REQ-003 Parameter MEM_DEPTH, default 64, number of 32-bit data-memory words.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 WB_en_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control bits from the EXE/MEM register.
REQ-007 PC_in  in  32  instruction PC, passed through.
REQ-008 ALU_result_in  in  32  byte address for loads/stores; writeback value otherwise.
REQ-009 ST_val_in  in  32  store data.
REQ-010 Dest_in  in  4  destination register index.
REQ-011 ready  out  1  combinational; 0 = freeze all upstream stages this cycle.
REQ-012 PC, ALU_result, MEM_result  out  32 each  registered MEM/WB values.
REQ-013 WB_en, MEM_R_EN  out  1 each  registered MEM/WB controls.
REQ-014 Dest  out  4  registered destination index.

Function
REQ-015 Memory request = MEM_R_EN_in | MEM_W_EN_in; with both high the access SHALL be a store, and MEM_R_EN output SHALL be 0.
REQ-016 FSM states IDLE and ACCESS plus a 4-bit counter cnt; IDLE with request -> ACCESS, cnt <= 1; ACCESS with cnt < ACCESS_CYCLES-1 -> cnt <= cnt+1; ACCESS with cnt == ACCESS_CYCLES-1 -> IDLE, cnt <= 0.
REQ-017 ready SHALL be 0 in IDLE with request and in ACCESS with cnt < ACCESS_CYCLES-1; 1 otherwise (stall = ACCESS_CYCLES-1 cycles per memory op; 0 for non-memory ops).
REQ-018 Upstream holds all *_in inputs stable while ready=0; this block SHALL sample them only on the completing cycle.
REQ-019 Word index = (ALU_result_in - MEM_BASE) >> 2; bits [1:0] ignored.
REQ-020 In range = ALU_result_in >= MEM_BASE and < MEM_BASE + 4*MEM_DEPTH; out of range: store discarded, load returns 0, latency unchanged.
REQ-021 Store SHALL write ST_val_in to memory only at the completing edge (ready=1, ACCESS); exactly one write per store.
REQ-022 Load data SHALL be read asynchronously at the completing cycle and registered into MEM_result.
REQ-023 MEM/WB registers SHALL load inputs (MEM_result from memory for loads, else 0) on every edge where ready=1.
REQ-024 On every edge where ready=0, MEM/WB SHALL load a bubble: WB_en=0, MEM_R_EN=0, other fields unchanged.
REQ-025 Back-to-back memory ops: completion returns to IDLE; the next op then enters ACCESS on the following edge with no extra idle cycle.
REQ-026 A load reading an address stored by the immediately preceding store SHALL return the new value.

Reset
REQ-027 rst SHALL force state IDLE, cnt 0, and all registered outputs 0 immediately, independent of clk.
REQ-028 Reset mid-access SHALL abort it: no memory write, ready=1 after rst deasserts with no request pending.
REQ-029 Data-memory contents SHALL NOT be cleared by rst.

Structure
REQ-030 Shared package holds the state enum (IDLE, ACCESS) and default constants MEM_BASE and MEM_DEPTH.
REQ-031 One sub-module data_memory: MEM_DEPTH x 32, synchronous write enable, asynchronous read.

Verification
REQ-032 Store ST_val_in=32'hDEADBEEF to 1028 -> ready low 3 cycles, one write to word 1, WB_en=0 throughout.
REQ-033 Then load from 1028 with WB_en_in=1, Dest_in=5 -> after 4 cycles MEM_result=32'hDEADBEEF, WB_en=1, MEM_R_EN=1, Dest=5; bubbles during stall.
REQ-034 ALU op, no memory access, ALU_result_in=7 -> ready stays 1, next edge ALU_result=7.
REQ-035 Load from 1020 and from 1280 -> full 4-cycle latency, MEM_result=0; store to 1280 leaves all words unchanged.
REQ-036 rst asserted at cnt=2 of a store to 1032 -> outputs 0 at once, word 2 unchanged, ready=1 after release.
REQ-037 Store 5 to 1024 then immediately load 1024 -> load returns 5; each op stalls exactly 3 cycles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encoding and default
// geometry of the data memory.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_ACCESS_CYCLES = 4;
  localparam int unsigned DEFAULT_MEM_BASE      = 1024;
  localparam int unsigned DEFAULT_MEM_DEPTH     = 64;

  // Word-index width; a single-word memory still needs one address bit.
  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module data_memory #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle load/store into a local data memory,
// stalling upstream through ready, then loading the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
  parameter logic [31:0] MEM_BASE      = 32'(DEFAULT_MEM_BASE),
  parameter int unsigned MEM_DEPTH     = DEFAULT_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ST_val_in,
  input  logic [3:0]  Dest_in,
  output logic        ready,
  output logic [31:0] PC,
  output logic [31:0] ALU_result,
  output logic [31:0] MEM_result,
  output logic        WB_en,
  output logic        MEM_R_EN,
  output logic [3:0]  Dest
);

  localparam int unsigned AW       = addr_bits(MEM_DEPTH);
  localparam logic [3:0]  LAST_CNT = 4'(ACCESS_CYCLES - 1);
  localparam logic [32:0] MEM_END  = {1'b0, MEM_BASE} + 33'(4 * MEM_DEPTH);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        req, is_store, is_load, done, in_range, mem_we;
  logic [31:0] offset, rdata;
  logic [AW-1:0] word_idx;

  // Stores win when both enables are set.
  assign req      = MEM_R_EN_in | MEM_W_EN_in;
  assign is_store = MEM_W_EN_in;
  assign is_load  = MEM_R_EN_in & ~MEM_W_EN_in;

  assign offset   = ALU_result_in - MEM_BASE;
  assign word_idx = AW'(offset >> 2);
  assign in_range = ({1'b0, ALU_result_in} >= {1'b0, MEM_BASE}) &&
                    ({1'b0, ALU_result_in} <  MEM_END);

  assign done   = (state == ACCESS) && (cnt == LAST_CNT);
  assign mem_we = done & is_store & in_range;

  data_memory #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (ST_val_in),
    .rdata (rdata)
  );

  // Handshake: ready=0 freezes upstream, which then holds every *_in input
  // stable; inputs are consumed only on a cycle where ready=1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b1;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = ACCESS;
          cnt_nxt   = 4'd1;
          ready     = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt < LAST_CNT) begin
          cnt_nxt = cnt + 4'd1;
          ready   = 1'b0;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MEM/WB register: advance on ready, otherwise insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC         <= 32'd0;
      ALU_result <= 32'd0;
      MEM_result <= 32'd0;
      WB_en      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      Dest       <= 4'd0;
    end else if (ready) begin
      PC         <= PC_in;
      ALU_result <= ALU_result_in;
      MEM_result <= (is_load && in_range) ? rdata : 32'd0;
      WB_en      <= WB_en_in;
      MEM_R_EN   <= is_load;
      Dest       <= Dest_in;
    end else begin
      WB_en    <= 1'b0;
      MEM_R_EN <= 1'b0;
    end
  end

endmodule
